// File: rtl/uart_line_echo_if.sv
// FIFO-side handshake between the line-echo stage and the UART core.
// The echo stage is the master: it pops the RX FIFO and pushes the TX FIFO.
interface uart_line_echo_if;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] wr_data;
    logic       wr_uart;

    modport master (
        input  rx_empty,
        input  rd_data,
        input  tx_full,
        output rd_uart,
        output wr_data,
        output wr_uart
    );

    modport slave (
        output rx_empty,
        output rd_data,
        output tx_full,
        input  rd_uart,
        input  wr_data,
        input  wr_uart
    );
endinterface

// File: rtl/uart_line_echo.sv
// Line echo stage: collects RX bytes up to TERM (or DEPTH bytes), then
// writes the line back with every byte incremented by INC, followed by CR LF.
module uart_line_echo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter logic [7:0]  TERM   = 8'h0D,
    parameter logic [7:0]  INC    = 8'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_line_echo_if.master       fifo,
    output logic                   busy,
    output logic                   overflow,
    output logic [7:0]             line_cnt
);

    typedef enum logic [1:0] {
        COLLECT,
        SEND,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      CR       = 8'h0D;
    localparam logic [7:0]      LF       = 8'h0A;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     count, count_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [ADDR_W:0]     last_idx;
    logic [7:0]          line_buf [DEPTH];

    logic                rd_strobe;
    logic                wr_strobe;
    logic [7:0]          wr_byte;
    logic                store_en;
    logic                ovf_set;
    logic                line_done;

    assign last_idx = count - 1'b1;

    // Strobes are held low while reset is asserted so no FIFO entry is
    // consumed or produced by a cycle whose state update is being discarded.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        wr_byte   = 8'h00;
        store_en  = 1'b0;
        ovf_set   = 1'b0;
        line_done = 1'b0;

        if (!reset) begin
            unique case (state)
                COLLECT: begin
                    if (!fifo.rx_empty) begin
                        rd_strobe = 1'b1;
                        if (fifo.rd_data == TERM) begin
                            idx_nxt   = '0;
                            state_nxt = (count == '0) ? SEND_CR : SEND;
                        end else begin
                            store_en  = 1'b1;
                            count_nxt = count + 1'b1;
                            if (count_nxt == FULL_CNT) begin
                                ovf_set   = 1'b1;
                                idx_nxt   = '0;
                                state_nxt = SEND;
                            end
                        end
                    end
                end

                SEND: begin
                    if (!fifo.tx_full) begin
                        wr_strobe = 1'b1;
                        wr_byte   = line_buf[idx] + INC;
                        if ({1'b0, idx} == last_idx) begin
                            state_nxt = SEND_CR;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end

                SEND_CR: begin
                    if (!fifo.tx_full) begin
                        wr_strobe = 1'b1;
                        wr_byte   = CR;
                        state_nxt = SEND_LF;
                    end
                end

                SEND_LF: begin
                    if (!fifo.tx_full) begin
                        wr_strobe = 1'b1;
                        wr_byte   = LF;
                        count_nxt = '0;
                        idx_nxt   = '0;
                        line_done = 1'b1;
                        state_nxt = COLLECT;
                    end
                end

                default: begin
                    state_nxt = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            count    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            line_cnt <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            idx   <= idx_nxt;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (line_done) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // Buffer contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (store_en) begin
            line_buf[count[ADDR_W-1:0]] <= fifo.rd_data;
        end
    end

    assign fifo.rd_uart = rd_strobe;
    assign fifo.wr_uart = wr_strobe;
    assign fifo.wr_data = wr_byte;
    assign busy         = (state != COLLECT);

endmodule
